// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// This is the instruction fetch stage. It sits directly upstream of decode. It
// holds the PC and issues word reads to a single-port program RAM. The RAM has
// a synchronous read with 1-cycle latency. Returned words are buffered in a
// small FIFO together with their byte PC. The FIFO head is presented to decode
// on a valid/ready handshake.
//
// A redirect from execute (branch, jump or trap) does the following:
//   - flushes the FIFO,
//   - drops the response that is still in flight,
//   - issues a read at the target in the same cycle.
//
// Optional feature (compile-time macro FETCH_MISALIGN_TRAP_EN):
//   When this macro is defined, a redirect to a target that is not 4-byte
//   aligned does not issue a read. It raises fetch_fault and parks the unit in
//   HALT. Only a later aligned redirect leaves HALT.
//   When the macro is undefined, the low two target bits are ignored and
//   fetch_fault is tied to 0.
//
// Parameters:
//   ADDR_BITS  : program memory word-address width (PC is ADDR_BITS+2 bits)
//   DATA_WIDTH : instruction width
//   RESET_PC   : byte address of the first fetch after reset (4-byte aligned)
//   FIFO_DEPTH : instruction buffer entries (>= 2 for 1 instr/cycle)
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   prog_addr      out  word address to program memory
//   prog_rd_en     out  read issued this cycle, data returns next cycle
//   prog_rd_data   in   program memory read data (cycle after prog_rd_en)
//   redirect_valid in   execute requests a PC change this cycle
//   redirect_pc    in   redirect target byte address
//   instr_valid    out  instr/instr_pc hold a valid instruction
//   instr_ready    in   decode accepts (transfer on valid && ready)
//   instr          out  instruction word (0 when not valid)
//   instr_pc       out  byte address of instr (0 when not valid)
//   fetch_fault    out  misaligned redirect fault (feature only, else 0)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int          ADDR_BITS  = 9,
    parameter int          DATA_WIDTH = 32,
    parameter int unsigned RESET_PC   = 0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_BITS-1:0]  prog_addr,
    output logic                  prog_rd_en,
    input  logic [DATA_WIDTH-1:0] prog_rd_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_BITS+1:0]  redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_BITS+1:0]  instr_pc,
    output logic                  fetch_fault
);

    localparam int PC_W  = ADDR_BITS + 2;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [PC_W-1:0]  PC_RESET = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0]  PC_STEP  = PC_W'(4);
    localparam logic [PC_W-1:0]  PC_ALIGN = ~PC_W'(3);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;
`else
    typedef enum logic {
        ST_BOOT,
        ST_RUN
    } state_t;
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;

    // Read issued last cycle that has not been squashed, with its byte PC.
    logic              inflight_q;
    logic [PC_W-1:0]   inflight_pc_q;

    // Instruction buffer
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PC_W-1:0]       fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]      count_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic              fault_q, fault_d;
`endif

    // ------------------------------------------------------------------------
    // Handshake and control
    // ------------------------------------------------------------------------
    logic              pop;
    logic              push;
    logic              redirect;
    logic [PC_W-1:0]   redirect_target;
    logic [PC_W-1:0]   issue_pc;
    int                occupancy;

    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready;

    // A redirect arriving while reset is held must not leak a read request.
    assign redirect    = redirect_valid && rst_n;

    // The response that lands at this edge is dropped if a redirect is
    // present in the same cycle. That response belongs to the old path.
    assign push        = inflight_q && !redirect;

    assign redirect_target = redirect_pc & PC_ALIGN;

    // This counts slots that are already committed: entries in the buffer
    // plus the read in flight, minus the entry decode takes this cycle.
    // Issuing only while this stays below the depth means a returning
    // response always has a slot.
    always_comb begin
        occupancy = int'(count_q) + int'(inflight_q) - int'(pop);
    end

    // NOTE: every variable driven here gets a default first. Otherwise a
    // path that skips an assignment infers a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        issue_pc   = pc_q;
        prog_rd_en = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d    = fault_q;
`endif

        if (redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                // Flush only. There is nothing valid to fetch at this target.
                state_d = ST_HALT;
                fault_d = 1'b1;
            end else begin
                prog_rd_en = 1'b1;
                issue_pc   = redirect_target;
                pc_d       = redirect_target + PC_STEP;
                state_d    = ST_RUN;
                fault_d    = 1'b0;
            end
`else
            prog_rd_en = 1'b1;
            issue_pc   = redirect_target;
            pc_d       = redirect_target + PC_STEP;
            state_d    = ST_RUN;
`endif
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (occupancy < FIFO_DEPTH) begin
                        prog_rd_en = 1'b1;
                        pc_d       = pc_q + PC_STEP;
                    end
                end
                default: begin
                    // HALT: wait for an aligned redirect.
                end
            endcase
        end
    end

    assign prog_addr = issue_pc[PC_W-1:2];

    // ------------------------------------------------------------------------
    // Sequential control state
    // ------------------------------------------------------------------------
    // NOTE: registers use non-blocking assignments. Every flop then samples
    // pre-edge values, whatever order the statements are in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= PC_RESET;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= prog_rd_en;
            if (prog_rd_en) begin
                inflight_pc_q <= issue_pc;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q    <= fault_d;
`endif
            if (redirect) begin
                // A pop in this cycle still completes at decode. The buffer
                // is emptied regardless.
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
                end
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // NOTE: buffer storage has no reset. Validity is tracked by count_q, and
    // stale entries never reach the outputs because of the gating below.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= prog_rd_data;
            fifo_pc[wr_ptr_q]   <= inflight_pc_q;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Outputs are zeroed while empty, so reset and flush present clean zeros
    // rather than stale buffer contents.
    assign instr    = instr_valid ? fifo_data[rd_ptr_q] : '0;
    assign instr_pc = instr_valid ? fifo_pc[rd_ptr_q]   : '0;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// This is the testbench for fetch_unit at its default parameters.
//
// A behavioural single-port RAM model answers the program-memory reads.
// Each stimulus step pushes the instructions it expects decode to receive into
// a scoreboard queue. A monitor pops and compares that queue on every
// valid && ready transfer. Cycle-exact properties are checked inline:
//   - reset values,
//   - latency,
//   - stall behaviour,
//   - flush behaviour.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int ADDR_BITS  = 9;
    localparam int DATA_WIDTH = 32;
    localparam int PC_W       = ADDR_BITS + 2;

    typedef struct packed {
        logic [PC_W-1:0]       pc;
        logic [DATA_WIDTH-1:0] data;
    } exp_t;

    logic                  clk;
    logic                  rst_n;
    logic [ADDR_BITS-1:0]  prog_addr;
    logic                  prog_rd_en;
    logic [DATA_WIDTH-1:0] prog_rd_data;
    logic                  redirect_valid;
    logic [PC_W-1:0]       redirect_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr;
    logic [PC_W-1:0]       instr_pc;
    logic                  fetch_fault;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    logic [DATA_WIDTH-1:0] mem [1 << ADDR_BITS];

    fetch_unit #(
        .ADDR_BITS  (ADDR_BITS),
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_PC   (0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .prog_addr      (prog_addr),
        .prog_rd_en     (prog_rd_en),
        .prog_rd_data   (prog_rd_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory: synchronous read, 1-cycle latency.
    always @(posedge clk) begin
        if (prog_rd_en) prog_rd_data <= mem[prog_addr];
    end

    // Program image. Words 0..3 are the first instructions of the test
    // program. Every other word encodes its own byte address, so a wrong
    // address or a dropped/duplicated fetch shows up in the data.
    function automatic logic [DATA_WIDTH-1:0] word_at(logic [PC_W-1:0] pc);
        case (pc[PC_W-1:2])
            9'd0:    return 32'h0000_0013;
            9'd1:    return 32'h0010_0093;
            9'd2:    return 32'h0020_0113;
            9'd3:    return 32'h0030_0193;
            default: return {16'hC0DE, 5'd0, pc};
        endcase
    endfunction

    initial begin
        for (int i = 0; i < (1 << ADDR_BITS); i++) begin
            mem[i] = word_at(PC_W'(i * 4));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_pc(input logic [PC_W-1:0] pc);
        exp_t e;
        e.pc   = pc;
        e.data = word_at(pc);
        sb_q.push_back(e);
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compares every transfer to decode.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_pc", 32'(instr_pc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_instr_pc", 32'(instr_pc), 32'(e.pc));
                check("sb_instr", instr, e.data);
            end
        end
    end

    // Watchdog: the directed sequence is short. This is only a backstop.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // ---------------- Reset values ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr",       instr,            32'd0);
        check("rst_instr_pc",    32'(instr_pc),    32'd0);
        check("rst_prog_rd_en",  32'(prog_rd_en),  32'd0);
        check("rst_prog_addr",   32'(prog_addr),   32'd0);
        check("rst_fetch_fault", 32'(fetch_fault), 32'd0);

        // ---------------- Latency after release, then stall ----------------
        #2 rst_n = 1'b1;
        @(negedge clk);                          // after edge 1: BOOT -> RUN
        check("boot_valid",      32'(instr_valid), 32'd0);
        check("run_first_issue", 32'(prog_rd_en),  32'd1);
        check("run_first_addr",  32'(prog_addr),   32'd0);
        @(negedge clk);                          // after edge 2
        check("lat_valid_e2",    32'(instr_valid), 32'd0);
        @(negedge clk);                          // after edge 3
        check("lat_valid_e3",    32'(instr_valid), 32'd1);
        check("lat_first_pc",    32'(instr_pc),    32'h000);
        check("lat_first_instr", instr,            32'h0000_0013);
        check("stall_no_issue",  32'(prog_rd_en),  32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_rd_en", 32'(prog_rd_en), 32'd0);
            check("stall_pc",    32'(instr_pc),   32'h000);
            check("stall_instr", instr,           32'h0000_0013);
        end

        // Release the stall: nothing is lost or duplicated.
        for (int i = 0; i < 6; i++) expect_pc(PC_W'(i * 4));
        cyc();
        instr_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 instr_ready = 1'b0;

        // ---------------- Redirect with a full buffer ----------------
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 11'h040;
        @(negedge clk);
        check("redir_rd_en", 32'(prog_rd_en), 32'd1);
        check("redir_addr",  32'(prog_addr),  32'h010);
        for (int i = 0; i < 5; i++) expect_pc(PC_W'(32'h040 + i * 4));
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_flush_valid", 32'(instr_valid), 32'd0);
        cyc();
        instr_ready = 1'b1;
        @(negedge clk);
        check("redir_target_valid", 32'(instr_valid), 32'd1);
        check("redir_target_pc",    32'(instr_pc),    32'h040);

        // Redirect that coincides with a pop, then a back-to-back redirect.
        repeat (4) @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 11'h100;
        cyc();
        redirect_pc    = 11'h200;
        expect_pc(11'h200);
        expect_pc(11'h204);
        @(negedge clk);
        check("b2b_valid_0", 32'(instr_valid), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid_1", 32'(instr_valid), 32'd0);
        cyc();
        @(negedge clk);
        check("b2b_target_pc", 32'(instr_pc), 32'h200);
        cyc();
        cyc();
        instr_ready = 1'b0;

        // ---------------- PC wrap ----------------
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 11'h7F8;
        expect_pc(11'h7F8);
        expect_pc(11'h7FC);
        expect_pc(11'h000);
        expect_pc(11'h004);
        cyc();
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        repeat (5) @(posedge clk);
        #1 instr_ready = 1'b0;

        // ---------------- Reset mid-stream ----------------
        cyc();
        cyc();
        @(negedge clk);
        check("pre_reset_valid", 32'(instr_valid), 32'd1);
        cyc();
        rst_n = 1'b0;
        #1;
        check("midrst_valid",    32'(instr_valid), 32'd0);
        check("midrst_instr",    instr,            32'd0);
        check("midrst_pc",       32'(instr_pc),    32'd0);
        check("midrst_rd_en",    32'(prog_rd_en),  32'd0);
        check("midrst_prog_addr", 32'(prog_addr),  32'd0);
        for (int i = 0; i < 4; i++) expect_pc(PC_W'(i * 4));
        @(negedge clk);
        #2;
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        check("rst2_valid_e1", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("rst2_valid_e2", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("rst2_valid_e3", 32'(instr_valid), 32'd1);
        repeat (4) @(posedge clk);
        #1 instr_ready = 1'b0;

        // ---------------- Misaligned redirect ----------------
`ifdef FETCH_MISALIGN_TRAP_EN
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 11'h042;
        @(negedge clk);
        check("mis_no_issue", 32'(prog_rd_en), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("halt_fault", 32'(fetch_fault), 32'd1);
            check("halt_valid", 32'(instr_valid), 32'd0);
            check("halt_rd_en", 32'(prog_rd_en),  32'd0);
            cyc();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 11'h080;
        expect_pc(11'h080);
        @(negedge clk);
        check("resume_rd_en", 32'(prog_rd_en), 32'd1);
        check("resume_addr",  32'(prog_addr),  32'h020);
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("resume_fault_clr", 32'(fetch_fault), 32'd0);
        check("resume_valid_0",   32'(instr_valid), 32'd0);
        cyc();
        instr_ready = 1'b1;
        @(negedge clk);
        check("resume_target_pc", 32'(instr_pc), 32'h080);
        cyc();
        instr_ready = 1'b0;
`else
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 11'h042;
        expect_pc(11'h040);
        @(negedge clk);
        check("mis_rd_en", 32'(prog_rd_en), 32'd1);
        check("mis_addr",  32'(prog_addr),  32'h010);
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("mis_fault_tied", 32'(fetch_fault), 32'd0);
        check("mis_valid_0",    32'(instr_valid), 32'd0);
        cyc();
        instr_ready = 1'b1;
        @(negedge clk);
        check("mis_aligned_pc", 32'(instr_pc), 32'h040);
        cyc();
        instr_ready = 1'b0;
`endif

        repeat (3) cyc();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
